// File: rtl/rd_mux_sequencer.sv
// ============================================================================
// Module   : rd_mux_sequencer
// Purpose  : Per-lane sequencer driving one registered rdDataMux through
//            multi-beat operand reads, with output valid/last/backpressure.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rd_mux_sequencer #(
    parameter  int DATA_WIDTH      = 8,
    parameter  int N               = 4,
    parameter  int MAX_BEATS       = 16,
    parameter  int ENABLE_STALLING = 1,
    localparam int SELW            = $clog2(N),
    localparam int BW              = $clog2(MAX_BEATS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [SELW-1:0]            req_base0,
    input  logic [SELW-1:0]            req_base1,
    input  logic [BW-1:0]              req_beats_m1,
    input  logic                       req_scalar,
    input  logic [DATA_WIDTH-1:0]      req_scalar_data,
    output logic [1:0][SELW-1:0]       mux_sel,
    output logic                       mux_uses_scalar,
    output logic [DATA_WIDTH-1:0]      mux_scalar_data,
    output logic                       mux_stall,
    output logic                       data_valid,
    output logic                       data_last,
    input  logic                       data_ready,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [SELW-1:0]         r_base0;
    logic [SELW-1:0]         r_base1;
    logic [BW-1:0]           r_beats_m1;
    logic [BW-1:0]           r_beat;
    logic                    r_uses_scalar;
    logic [DATA_WIDTH-1:0]   r_scalar_data;
    logic                    r_valid;
    logic                    r_last;

    logic                    w_ready_eff;
    logic                    w_stall;
    logic                    w_accept;
    logic                    w_issue;
    logic                    w_last_beat;
    logic [SELW-1:0]         w_beat_sel;

    // Without stalling support the consumer is assumed to always take the beat.
    assign w_ready_eff = (ENABLE_STALLING != 0) ? data_ready : 1'b1;
    assign w_stall     = r_valid && !w_ready_eff;
    assign w_accept    = req_valid && (r_state == S_IDLE);
    assign w_issue     = (r_state == S_ISSUE) && !w_stall;
    assign w_last_beat = (r_beat == r_beats_m1);

    // Bank index wraps modulo N by truncation to SELW bits.
    assign w_beat_sel  = SELW'(r_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_issue && w_last_beat) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!w_stall) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base0       <= '0;
            r_base1       <= '0;
            r_beats_m1    <= '0;
            r_beat        <= '0;
            r_uses_scalar <= 1'b0;
            r_scalar_data <= '0;
            r_valid       <= 1'b0;
            r_last        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_base0       <= req_base0;
                r_base1       <= req_base1;
                r_beats_m1    <= req_beats_m1;
                r_beat        <= '0;
                r_uses_scalar <= req_scalar;
                if (req_scalar) begin
                    r_scalar_data <= req_scalar_data;
                end
            end

            // Valid/last shadow the mux's one-cycle registered output.
            if (w_issue) begin
                r_valid <= 1'b1;
                r_last  <= w_last_beat;
                if (!w_last_beat) begin
                    r_beat <= r_beat + 1'b1;
                end
            end else if (!w_stall) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            if ((r_state != S_IDLE) && (w_state_nxt == S_IDLE)) begin
                r_uses_scalar <= 1'b0;
            end
        end
    end

    assign req_ready       = (r_state == S_IDLE);
    assign mux_sel[0]      = r_base0 + w_beat_sel;
    assign mux_sel[1]      = r_base1 + w_beat_sel;
    assign mux_uses_scalar = r_uses_scalar;
    assign mux_scalar_data = r_scalar_data;
    assign mux_stall       = w_stall;
    assign data_valid      = r_valid;
    assign data_last       = r_last;
    assign busy            = (r_state != S_IDLE) || r_valid;

endmodule

`default_nettype wire

// File: doc/rd_mux_sequencer.md
Name: rd_mux_sequencer

Overview:
- Per-lane controller that sequences one rdDataMux instance for multi-beat vector operand reads.
- Accepts one read request (two base bank indices, beat count, optional scalar operand) through a valid/ready handshake.
- Each beat, drives the mux sel pair, uses_scalar_data and stall; bank indices step modulo N.
- Tracks the mux's 1-cycle registered latency so downstream consumers get data_valid/data_last aligned with the mux output, with backpressure.

Parameters:
- DATA_WIDTH, 8, operand element width; must match the sequenced mux.
- N, 4, banks per operand; sel width SELW = $clog2(N), N a power of two, N >= 2.
- MAX_BEATS, 16, maximum beats per request; BW = $clog2(MAX_BEATS).
- ENABLE_STALLING, 1, 1 = honour data_ready backpressure; 0 = data_ready ignored, mux_stall tied 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_base0  in  SELW  starting bank index, operand 0.
- req_base1  in  SELW  starting bank index, operand 1.
- req_beats_m1  in  BW  beat count minus 1 (0 means 1 beat).
- req_scalar  in  1  operand 0 is the scalar for the whole request.
- req_scalar_data  in  DATA_WIDTH  scalar value.
- mux_sel  out  2xSELW  to mux sel[1:0].
- mux_uses_scalar  out  1  to mux uses_scalar_data.
- mux_scalar_data  out  DATA_WIDTH  to mux scalar_data.
- mux_stall  out  1  to mux stall.
- data_valid  out  1  mux out holds a valid beat this cycle.
- data_last  out  1  the valid beat is the request's final beat.
- data_ready  in  1  consumer accepts the beat this cycle.
- busy  out  1  state != IDLE or data_valid.

Behaviour:
- Reset rst, synchronous, active-high; clock clk.
- Reset values: state IDLE; mux_sel 0/0; mux_uses_scalar 0; mux_scalar_data 0; data_valid 0; data_last 0; beat counter 0.
- Reset mid-request abandons the request. data_valid is 0 in the first cycle after reset.
- States are IDLE, ISSUE and DRAIN.
- req_ready = (state == IDLE). A request is accepted when req_valid && req_ready.
- On accept, register the following and go to ISSUE:
  - base0, base1, beats_m1;
  - req_scalar into mux_uses_scalar;
  - req_scalar_data into mux_scalar_data (else leave it unchanged).
- The beat counter b clears to 0 on accept.
- In ISSUE, mux_sel[k] = (base_k + b) mod N. It is combinational from registered state and wraps naturally at SELW bits.
- mux_stall = ENABLE_STALLING && data_valid && !data_ready.
- Issue condition: an issue occurs in a cycle when state == ISSUE && !mux_stall. The mux samples mux_sel at that edge.
- On issue:
  - data_valid <= 1 and data_last <= (b == beats_m1) at the next edge;
  - if b == beats_m1, go to DRAIN; otherwise b <= b + 1.
- In any cycle with no issue and no stall, data_valid <= 0 (the beat is consumed or was absent).
- While mux_stall = 1:
  - data_valid, data_last and b hold;
  - the mux holds its output;
  - mux_sel must not change.
- DRAIN → IDLE on the edge where data_valid && data_ready, with data_valid <= 0.
- When ENABLE_STALLING = 0, data_ready is treated as 1.
- Throughput is 1 beat per cycle with no bubbles while data_ready = 1. A request of B beats occupies the sequencer for B+1 cycles from accept to IDLE.
- Latency: the first data_valid appears 2 cycles after the accept edge (accept edge → ISSUE edge → data).
- mux_uses_scalar holds for every beat and clears to 0 on entry to IDLE.
- A request with beats_m1 = MAX_BEATS-1 must complete without counter overflow.
- Simultaneous events:
  - a new req_valid in DRAIN is not accepted until IDLE;
  - data_ready deasserting on the issue cycle of the last beat keeps the state in DRAIN until it is accepted.
- req_* inputs are don't-care outside the accept cycle.

Test Plan:
- Single beat, N=4: base0=1, base1=2, beats_m1=0, data_ready=1.
  - mux_sel=(1,2) for one cycle.
  - data_valid=1 and data_last=1 two cycles after accept.
  - req_ready back to 1 one cycle after that.
- Wrap-around: base0=3, base1=0, beats_m1=5, data_ready=1.
  - mux_sel[0] sequence 3,0,1,2,3,0; mux_sel[1] sequence 0,1,2,3,0,1.
  - Six consecutive data_valid beats, data_last only on the 6th.
- Backpressure, ENABLE_STALLING=1, beats_m1=3: drop data_ready for 3 cycles on beat 2.
  - mux_stall=1 for those 3 cycles; mux_sel frozen at beat 3's index.
  - No beat lost or duplicated; 4 beats total.
- Scalar: req_scalar=1, req_scalar_data=0xA5, beats_m1=2.
  - mux_uses_scalar=1 and mux_scalar_data=0xA5 on all 3 beats.
  - mux_uses_scalar=0 once IDLE.
- Reset mid-request: assert rst during beat 2 of an 8-beat request.
  - All outputs at reset values next cycle, req_ready=1.
  - A new 1-beat request then completes normally.
- ENABLE_STALLING=0: data_ready held 0 for a 4-beat request.
  - mux_stall stays 0; 4 beats issued back-to-back; FSM returns to IDLE.
